// File: rtl/condicionador_pkg.sv
// Shared constants for the robot input conditioner.
// Channel map, default sizes and counter width helper.
package condicionador_pkg;

   localparam int N_IN_DEF = 6;
   localparam int DEB_DEF  = 500000;

   localparam int CH_L = 0;
   localparam int CH_B = 1;
   localparam int CH_E = 2;
   localparam int CH_D = 3;
   localparam int CH_F = 4;
   localparam int CH_A = 5;

   function automatic int cnt_width(input int deb);
      return $clog2(deb + 1);
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// One input channel: 2-flop sync, debounce counter,
// accepted level and single-cycle edge pulses.
module debounce_canal
   import condicionador_pkg::*;
#(
   parameter int   DEB_CYCLES = DEB_DEF,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          diff;
   logic          done;

   assign diff = s2 ^ stable;
   assign done = diff && (cnt == CNT_MAX);
   assign busy = (cnt != '0);

   // two-stage synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // count consecutive cycles of disagreement; any agreement restarts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!diff || done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end

   // accept the new level and pulse the matching edge in one update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (done) begin
            stable <= s2;
            rise   <= s2;
            fall   <= ~s2;
         end
      end
   end

endmodule

// File: rtl/condicionador_entradas.sv
// Input front end: per-channel debounce plus the
// power toggle driven by the accepted L-channel press.
module condicionador_entradas
   import condicionador_pkg::*;
#(
   parameter int              N_IN       = N_IN_DEF,
   parameter int              DEB_CYCLES = DEB_DEF,
   parameter logic [N_IN-1:0] RST_VAL    = '0,
   parameter int              TGL_IDX    = CH_L
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] raw_in,
   output logic [N_IN-1:0] stable,
   output logic [N_IN-1:0] rise,
   output logic [N_IN-1:0] fall,
   output logic            liga,
   output logic [N_IN-1:0] busy
);

   for (genvar i = 0; i < N_IN; i++) begin : g_ch
      debounce_canal #(
         .DEB_CYCLES (DEB_CYCLES),
         .RST_VAL    (RST_VAL[i])
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (raw_in[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .busy   (busy[i])
      );
   end

   // power state flips one cycle after each accepted press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         liga <= 1'b0;
      end else if (rise[TGL_IDX]) begin
         liga <= ~liga;
      end
   end

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas
// with DEB_CYCLES=4, all channels reset low.
module tb_condicionador_entradas;

   logic       clk;
   logic       rst_n;
   logic [5:0] raw_in;
   logic [5:0] stable;
   logic [5:0] rise;
   logic [5:0] fall;
   logic       liga;
   logic [5:0] busy;

   int total = 0;
   int bad   = 0;

   condicionador_entradas #(
      .N_IN       (6),
      .DEB_CYCLES (4),
      .RST_VAL    (6'b000000),
      .TGL_IDX    (0)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_in (raw_in),
      .stable (stable),
      .rise   (rise),
      .fall   (fall),
      .liga   (liga),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      int         npulse;
      int         nliga;
      int         hits;
      int         seen_busy;
      int         nr;
      int         nf;
      logic       m;
      logic [5:0] pat;

      rst_n  = 1'b0;
      raw_in = 6'b000000;
      repeat (3) step();
      chk("rst_stable", stable, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_liga", liga, 0);
      chk("rst_busy", busy, 0);

      // release with raw equal to reset level
      rst_n  = 1'b1;
      npulse = 0;
      nliga  = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rise != 0 || fall != 0) npulse++;
         if (liga) nliga++;
      end
      chk("quiet_pulse", npulse, 0);
      chk("quiet_liga", nliga, 0);

      // clean step on channel 2
      raw_in[2] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("step_stable", stable, 0);
         chk("step_busy", busy, (k >= 3) ? 6'h04 : 6'h00);
         chk("step_rise", rise, 0);
      end
      step();
      chk("step_stable6", stable, 6'h04);
      chk("step_rise6", rise, 6'h04);
      chk("step_fall6", fall, 0);
      chk("step_busy6", busy, 0);
      step();
      chk("step_rise7", rise, 0);
      chk("step_stable7", stable, 6'h04);
      raw_in[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("stepd_fall", fall, (k == 6) ? 6'h04 : 6'h00);
      end
      chk("stepd_stable", stable, 0);
      chk("stepd_liga", liga, 0);

      // bounce on channel 3
      pat       = 6'b011011;
      hits      = 0;
      seen_busy = 0;
      for (int i = 0; i < 6; i++) begin
         raw_in[3] = pat[i];
         step();
         if (rise[3] || stable[3]) hits++;
         if (busy[3]) seen_busy++;
      end
      raw_in[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rise[3] || stable[3]) hits++;
         if (busy[3]) seen_busy++;
      end
      chk("bounce_hits", hits, 0);
      chk("bounce_busy_seen", (seen_busy > 0), 1);
      chk("bounce_busy_end", busy[3], 0);

      // three presses on L toggle liga
      m  = 1'b0;
      nr = 0;
      nf = 0;
      for (int p = 0; p < 3; p++) begin
         for (int h = 0; h < 20; h++) begin
            raw_in[0] = (h < 10);
            step();
            chk("tgl_liga", liga, m);
            if (rise[0]) nr++;
            if (fall[0]) nf++;
            m = m ^ rise[0];
         end
      end
      raw_in[0] = 1'b0;
      chk("tgl_rises", nr, 3);
      chk("tgl_falls", nf, 3);
      chk("tgl_final", liga, 1);

      // reset clears liga immediately
      rst_n = 1'b0;
      #1;
      chk("rst2_liga", liga, 0);
      step();
      rst_n = 1'b1;
      repeat (3) step();

      // all channels change together
      raw_in = 6'h3F;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("par_stable", stable, 0);
      end
      step();
      chk("par_rise", rise, 6'h3F);
      chk("par_stable6", stable, 6'h3F);
      chk("par_fall", fall, 0);
      chk("par_liga6", liga, 0);
      step();
      chk("par_rise7", rise, 0);
      chk("par_liga7", liga, 1);

      // reset in the middle of qualification
      rst_n  = 1'b0;
      raw_in = 6'h00;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      raw_in[5] = 1'b1;
      repeat (4) step();
      chk("midq_busy", busy, 6'h20);
      rst_n = 1'b0;
      #1;
      chk("midq_busy_clr", busy, 0);
      chk("midq_stable_clr", stable, 0);
      chk("midq_liga_clr", liga, 0);
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("midq_stable", stable, 0);
      end
      step();
      chk("midq_stable6", stable, 6'h20);
      chk("midq_rise6", rise, 6'h20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
